// File: rtl/keypad_scan_fifo.sv
// keypad_scan_fifo: matrix-keypad scanner with per-key debounce and a
// valid/ready key-code FIFO. Columns are strobed one-hot; row returns are
// synchronised and sampled once per SCAN_DIV clocks.
// Optional auto-repeat of a held key: define KEYPAD_SCAN_REPEAT_EN.
module keypad_scan_fifo #(
    parameter int ROWS         = 4,
    parameter int COLS         = 4,
    parameter int SCAN_DIV     = 500,
    parameter int DEBOUNCE     = 4,
    parameter int FIFO_DEPTH   = 4,
    parameter int REPEAT_DELAY = 50,
    parameter int REPEAT_RATE  = 10,
    localparam int CODE_W      = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ROWS-1:0]   row,
    output logic [COLS-1:0]   col,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    input  logic              key_ready,
    output logic              key_held,
    output logic              overflow
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DEBOUNCE,
        S_PRESSED,
        S_RELEASE
    } state_t;

    state_t            state, state_nx;
    logic [ROWS-1:0]   rs_meta, rs;
    logic [DIV_W-1:0]  div;
    logic              tick;
    logic [RW-1:0]     r, r_nx, low_row;
    logic [CW-1:0]     c, c_nx, act_col;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [COLS-1:0]   col_nx, col_rot;
    logic              push;
    logic [CODE_W-1:0] push_code;

    logic [CODE_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wp, rp;
    logic [OCC_W-1:0]  occ;
    logic              full, pop, wr;

`ifdef KEYPAD_SCAN_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    logic [REP_W-1:0] rpt, rpt_nx;
    logic             rpt_on, rpt_on_nx;
`else
    // Repeat timing has no effect in this build.
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_RATE};
`endif

    assign tick     = (div == DIV_W'(SCAN_DIV - 1));
    assign col_rot  = (col << 1) | (col >> (COLS - 1));
    assign key_held = (state == S_PRESSED) || (state == S_RELEASE);

    // Two-flop synchroniser for the asynchronous row returns.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rs_meta <= '0;
            rs      <= '0;
        end else begin
            rs_meta <= row;
            rs      <= rs_meta;
        end
    end

    // Scan divider; terminal count is the sample tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div <= '0;
        end else if (tick) begin
            div <= '0;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    // Lowest asserted synchronised row.
    always_comb begin
        low_row = '0;
        for (int unsigned i = ROWS; i > 0; i--) begin
            if (rs[i-1]) begin
                low_row = RW'(i - 1);
            end
        end
    end

    // Index of the currently strobed column.
    always_comb begin
        act_col = '0;
        for (int unsigned i = 0; i < COLS; i++) begin
            if (col[i]) begin
                act_col = CW'(i);
            end
        end
    end

    // Scanner state register and locked key coordinates.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            r     <= '0;
            c     <= '0;
            cnt   <= '0;
            col   <= COLS'(1);
`ifdef KEYPAD_SCAN_REPEAT_EN
            rpt    <= '0;
            rpt_on <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            r     <= r_nx;
            c     <= c_nx;
            cnt   <= cnt_nx;
            col   <= col_nx;
`ifdef KEYPAD_SCAN_REPEAT_EN
            rpt    <= rpt_nx;
            rpt_on <= rpt_on_nx;
`endif
        end
    end

    // Next-state, column advance and push decision, evaluated on sample ticks.
    always_comb begin
        state_nx = state;
        r_nx     = r;
        c_nx     = c;
        cnt_nx   = cnt;
        col_nx   = col;
        push     = 1'b0;
        if (state == S_IDLE) begin
            push_code = CODE_W'(int'(low_row) * COLS + int'(act_col));
        end else begin
            push_code = CODE_W'(int'(r) * COLS + int'(c));
        end
`ifdef KEYPAD_SCAN_REPEAT_EN
        rpt_nx    = rpt;
        rpt_on_nx = rpt_on;
`endif
        if (tick) begin
            case (state)
                S_IDLE: begin
                    if (|rs) begin
                        r_nx   = low_row;
                        c_nx   = act_col;
                        cnt_nx = CNT_W'(1);
                        if (DEBOUNCE == 1) begin
                            push     = 1'b1;
                            state_nx = S_PRESSED;
                        end else begin
                            state_nx = S_DEBOUNCE;
                        end
                    end else begin
                        col_nx = col_rot;
                    end
                end
                S_DEBOUNCE: begin
                    if (rs[r]) begin
                        cnt_nx = cnt + CNT_W'(1);
                        if (cnt == CNT_W'(DEBOUNCE - 1)) begin
                            push     = 1'b1;
                            state_nx = S_PRESSED;
                        end
                    end else begin
                        state_nx = S_IDLE;
                        col_nx   = col_rot;
                    end
                end
                S_PRESSED: begin
                    if (!rs[r]) begin
                        cnt_nx = CNT_W'(1);
                        // A single clear sample already satisfies a debounce of one.
                        if (DEBOUNCE == 1) begin
                            state_nx = S_IDLE;
                            col_nx   = col_rot;
                        end else begin
                            state_nx = S_RELEASE;
                        end
                    end else begin
`ifdef KEYPAD_SCAN_REPEAT_EN
                        if (int'(rpt) + 1 == (rpt_on ? REPEAT_RATE : REPEAT_DELAY)) begin
                            push      = 1'b1;
                            rpt_nx    = '0;
                            rpt_on_nx = 1'b1;
                        end else begin
                            rpt_nx = rpt + REP_W'(1);
                        end
`endif
                    end
                end
                S_RELEASE: begin
                    if (!rs[r]) begin
                        cnt_nx = cnt + CNT_W'(1);
                        if (cnt == CNT_W'(DEBOUNCE - 1)) begin
                            state_nx = S_IDLE;
                            col_nx   = col_rot;
                        end
                    end else begin
                        state_nx = S_PRESSED;
                    end
                end
                default: state_nx = S_IDLE;
            endcase
        end
`ifdef KEYPAD_SCAN_REPEAT_EN
        if (state_nx == S_PRESSED && state != S_PRESSED) begin
            rpt_nx    = '0;
            rpt_on_nx = 1'b0;
        end
`endif
    end

    assign full      = (occ == OCC_W'(FIFO_DEPTH));
    assign key_valid = (occ != '0);
    assign pop       = key_valid & key_ready;
    // A push into a full FIFO is only accepted if the head leaves in the same cycle.
    assign wr        = push & (~full | pop);
    assign key_code  = mem[rp];

    // Key-code FIFO storage, pointers, occupancy and overflow pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wp       <= '0;
            rp       <= '0;
            occ      <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr) begin
                mem[wp] <= push_code;
                wp      <= wp + PTR_W'(1);
            end
            if (pop) begin
                rp <= rp + PTR_W'(1);
            end
            occ      <= occ + OCC_W'(wr) - OCC_W'(pop);
            overflow <= push & full & ~pop;
        end
    end

endmodule

// File: doc/keypad_scan_fifo.md
Name: keypad_scan_fifo

Overview:
- Parametrised matrix-keypad scanner with per-key debounce and an output FIFO using a valid/ready handshake.
- Next generation of the fixed 4x4 scanner feeding MainModule's display path.
- Drives one-hot column strobes, samples row returns and encodes the pressed key.
- Queues key codes so the consumer (display/accumulator logic) may stall without losing presses.

Parameters:
- ROWS, 4, number of keypad rows (1..8)
- COLS, 4, number of keypad columns (1..8)
- SCAN_DIV, 500, clk cycles each column stays asserted (>=2)
- DEBOUNCE, 4, consecutive matching column samples to accept a press or a release (>=1)
- FIFO_DEPTH, 4, key-code queue entries (power of 2, >=2)
- REPEAT_DELAY, 50, samples before first auto-repeat (used only with macro)
- REPEAT_RATE, 10, samples between further auto-repeats (used only with macro)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- row  in  ROWS  raw row returns from keypad, active-high, asynchronous to clk
- col  out  COLS  one-hot column strobe, active-high
- key_code  out  CODE_W  FIFO head; CODE_W = max(1, $clog2(ROWS*COLS)); code = r*COLS + c
- key_valid  out  1  FIFO not empty
- key_ready  in  1  consumer accepts head when key_valid is high
- key_held  out  1  a debounced key is currently down
- overflow  out  1  one-cycle pulse when a code is dropped because the FIFO is full

Behaviour:
- Reset (rst=0, asynchronous) sets: col=1 (col[0]), divider=0, state=IDLE, FIFO empty, key_valid=0, key_code=0, key_held=0, overflow=0. Reset mid-press discards everything; after release of reset, scanning restarts at col[0].
- row passes through a 2-flop synchroniser; all decisions use the synchronised value rs.
- Divider counts 0..SCAN_DIV-1. Terminal count is a "sample tick": rs is evaluated, then the divider wraps.
- col advances (rotate left; col[COLS-1] wraps to col[0]) on a sample tick only in IDLE, or when leaving DEBOUNCE/RELEASE back to IDLE. col is frozen in all other states.
- States:
  - IDLE: on a tick with rs!=0, latch r = lowest set row index and c = active column index, set cnt=1, go to DEBOUNCE. If DEBOUNCE==1, push immediately and go to PRESSED.
  - DEBOUNCE: on each tick, if rs[r]=1 then cnt++. When cnt==DEBOUNCE: push code, go to PRESSED, set key_held=1. If rs[r]=0: go to IDLE and advance col.
  - PRESSED: on a tick with rs[r]=0, set cnt=1 and go to RELEASE.
  - RELEASE: on a tick with rs[r]=0, cnt++. When cnt==DEBOUNCE: key_held=0, go to IDLE, advance col. If rs[r]=1: return to PRESSED.
- Other rows asserting while locked on r are ignored (no multi-key detection, no ghost suppression).
- FIFO:
  - Push writes at tail. key_valid rises the cycle after a push into an empty FIFO.
  - Pop occurs when key_valid & key_ready; the head advances next cycle.
  - key_code holds the head whenever key_valid=1; its value is don't-care when key_valid=0.
  - Push when full with no pop in the same cycle: code dropped, overflow=1 for one cycle, contents unchanged.
  - Push and pop in the same cycle when full: both happen, no overflow.
  - Push and pop in the same cycle when empty is impossible (valid is low).
  - Pointers wrap modulo FIFO_DEPTH. A separate occupancy count (0..FIFO_DEPTH) distinguishes full from empty.

Optional Feature:
- Macro: KEYPAD_SCAN_REPEAT_EN.
- Defined: in PRESSED, a repeat counter increments per sample tick. After REPEAT_DELAY ticks the held code is pushed again, then every REPEAT_RATE ticks. Repeat pushes follow the normal overflow rule. The counter resets on entry to PRESSED; RELEASE pauses it, and a return to PRESSED from RELEASE resets it.
- Undefined: exactly one push per debounced press; REPEAT_* parameters are ignored; no repeat logic is synthesised.

Test Plan:
- Bench parameters for all scenarios: SCAN_DIV=4, DEBOUNCE=3, FIFO_DEPTH=4. The keypad model drives row[r]=1 only while col[c]=1 and key (r,c) is pressed.
- Reset: rst=0, with row toggling randomly -> col=0001, key_valid=0, key_held=0, overflow=0. Release rst with row=0 -> col steps 0001->0010->0100->1000->0001, one step every 4 clk.
- Press key (1,1) and hold, key_ready=1 -> col frozen at 0010. After 3 matching ticks: key_valid=1 with key_code=5 for one cycle, key_held=1. Release -> key_held=0 after 3 clear ticks, then scanning resumes at 0100.
- Bounce: key (2,3) asserted for one sample tick only -> no push, key_valid stays 0, col advances on the next tick.
- Overflow: key_ready=0, press/release keys 0,1,2,3,4 in turn -> FIFO holds 0,1,2,3; overflow pulses once on the key-4 push. Then key_ready=1 -> codes 0,1,2,3 emerge in order, then key_valid=0.
- Full with simultaneous push and pop: FIFO full, key_ready=1 on the exact push cycle of key 7 -> no overflow, tail entry=7.
- With KEYPAD_SCAN_REPEAT_EN, REPEAT_DELAY=5, REPEAT_RATE=2: hold key 9 for 12 ticks after acceptance -> pushes of 9 at acceptance and at ticks 5, 7, 9, 11.
